// File: rtl/float2fixed.sv
`default_nettype none
// ============================================================================
// float2fixed : 3-stage 16-bit float {s,e[4:0],m[9:0]} -> 44-bit fixed converter
// Rev 1.0
// ============================================================================
module float2fixed #(
  parameter int EXP_W   = 5,
  parameter int MANT_W  = 10,
  parameter int FLOAT_W = 1 + EXP_W + MANT_W,
  parameter int FIXED_W = (1 << EXP_W) + MANT_W + 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOAT_W-1:0] float_in,
  input  logic               valid_in,
  output logic               ready_in,
  output logic [FIXED_W-1:0] fixed_out,
  output logic               valid_out,
  input  logic               ready_out
);

  localparam int c_SIG_W = MANT_W + 1;
  localparam int c_MAG_W = FIXED_W - 1;

  logic               r_v1, r_v2, r_v3;
  logic               w_adv1, w_adv2, w_adv3;

  logic               r_s1_sign;
  logic               r_s1_zero;
  logic [EXP_W-1:0]   r_s1_exp;
  logic [c_SIG_W-1:0] r_s1_sig;

  logic               r_s2_sign;
  logic [c_MAG_W-1:0] r_s2_mag;

  logic [FIXED_W-1:0] r_fixed;

  logic [EXP_W:0]     w_shamt;
  logic [c_MAG_W-1:0] w_mag;
  logic [FIXED_W-1:0] w_fixed;

  // Backpressure chain: a stage may load when it is empty or its successor moves.
  always_comb begin
    w_adv3 = !r_v3 || ready_out;
    w_adv2 = !r_v2 || w_adv3;
    w_adv1 = !r_v1 || w_adv2;
  end

  assign ready_in  = w_adv1;
  assign valid_out = r_v3;
  assign fixed_out = r_fixed;

  // Shift amount is one bit wider than the exponent so exp=31 yields 32, not 0.
  always_comb begin
    w_shamt = {1'b0, r_s1_exp} + {{EXP_W{1'b0}}, 1'b1};
    w_mag   = r_s1_zero ? '0
                        : ({{(c_MAG_W-c_SIG_W){1'b0}}, r_s1_sig} << w_shamt);
    w_fixed = r_s2_sign ? (~{1'b0, r_s2_mag} + {{(FIXED_W-1){1'b0}}, 1'b1})
                        : {1'b0, r_s2_mag};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_fixed <= '0;
    end else begin
      if (w_adv1) r_v1 <= valid_in;
      if (w_adv2) r_v2 <= r_v1;
      if (w_adv3) begin
        r_v3    <= r_v2;
        r_fixed <= r_v2 ? w_fixed : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv1 && valid_in) begin
      r_s1_sign <= float_in[FLOAT_W-1];
      r_s1_exp  <= float_in[FLOAT_W-2 -: EXP_W];
      r_s1_sig  <= {1'b1, float_in[MANT_W-1:0]};
      r_s1_zero <= (float_in[FLOAT_W-2:0] == '0);
    end
    if (w_adv2 && r_v1) begin
      r_s2_sign <= r_s1_sign;
      r_s2_mag  <= w_mag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_float2fixed.sv
`default_nettype none
// ============================================================================
// tb_float2fixed : directed and swept self-checking bench for float2fixed
// Rev 1.0
// ============================================================================
module tb_float2fixed;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] float_in;
  logic        valid_in;
  logic        ready_in;
  logic [43:0] fixed_out;
  logic        valid_out;
  logic        ready_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  float2fixed dut (
    .clk       (clk),
    .reset     (reset),
    .float_in  (float_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .fixed_out (fixed_out),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  function automatic logic [43:0] model(input logic [15:0] f);
    logic [43:0] mag;
    if (f[14:0] == 15'd0) return 44'd0;
    mag = 44'({1'b1, f[9:0]}) << (int'(f[14:10]) + 1);
    return f[15] ? (44'd0 - mag) : mag;
  endfunction

  // Sends one item into an empty pipeline and reports latency (0 = timeout) and result.
  task automatic push_and_wait(input logic [15:0] f, output int lat, output logic [43:0] val);
    logic acc;
    @(posedge clk); #1;
    float_in  = f;
    valid_in  = 1'b1;
    ready_out = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
    end
    #1 valid_in = 1'b0;
    lat = 0;
    val = 'x;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        lat = i;
        val = fixed_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1; float_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_checks++;
    if (fixed_out !== 44'd0) begin n_fail++; $display("FAIL reset_fixed: got %h want 0", fixed_out); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_ready_in: got %b want 1", ready_in); end
  endtask

  task automatic test_zero();
    int lat; logic [43:0] val;
    push_and_wait(16'h0000, lat, val);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL zero_pos_latency: got %0d want 3", lat); end
    n_checks++;
    if (val !== 44'd0) begin n_fail++; $display("FAIL zero_pos_value: got %h want 0", val); end
    push_and_wait(16'h8000, lat, val);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL zero_neg_latency: got %0d want 3", lat); end
    n_checks++;
    if (val !== 44'd0) begin n_fail++; $display("FAIL zero_neg_value: got %h want 0", val); end
  endtask

  task automatic test_smallest();
    int lat; logic [43:0] val;
    push_and_wait(16'h0001, lat, val);
    n_checks++;
    if (val !== 44'h00000000802) begin n_fail++; $display("FAIL small_0001: got %h want 00000000802", val); end
    push_and_wait(16'h0400, lat, val);
    n_checks++;
    if (val !== 44'h00000001000) begin n_fail++; $display("FAIL small_0400: got %h want 00000001000", val); end
  endtask

  task automatic test_extremes();
    int lat; logic [43:0] val;
    push_and_wait(16'h7C00, lat, val);
    n_checks++;
    if (val !== 44'h40000000000) begin n_fail++; $display("FAIL ext_7C00: got %h want 40000000000", val); end
    push_and_wait(16'hFC00, lat, val);
    n_checks++;
    if (val !== 44'hC0000000000) begin n_fail++; $display("FAIL ext_FC00: got %h want C0000000000", val); end
    push_and_wait(16'h8401, lat, val);
    n_checks++;
    if (val !== 44'hFFFFFFFEFFC) begin n_fail++; $display("FAIL ext_8401: got %h want FFFFFFFEFFC", val); end
  endtask

  task automatic test_backpressure();
    logic [15:0] vin [6];
    logic [43:0] vexp [6];
    logic [43:0] got [$];
    logic [43:0] pval;
    logic        pstall, acc;
    bit          saw_low;
    int          idx;
    vin  = '{16'h0001, 16'h0400, 16'h8401, 16'h7C00, 16'h3C00, 16'hBC00};
    vexp = '{44'h00000000802, 44'h00000001000, 44'hFFFFFFFEFFC,
             44'h40000000000, 44'h00004000000, 44'hFFFFC000000};
    idx = 0; saw_low = 0; pstall = 0; pval = '0;
    got.delete();
    @(posedge clk); #1;
    ready_out = 1'b1; valid_in = 1'b1; float_in = vin[0];
    fork
      begin
        for (int c = 0; c < 40 && idx < 6; c++) begin
          @(negedge clk);
          acc = valid_in && ready_in;
          if (ready_in === 1'b0) saw_low = 1;
          @(posedge clk); #1;
          if (acc) begin
            idx++;
            if (idx < 6) float_in = vin[idx];
            else valid_in = 1'b0;
          end
        end
        valid_in = 1'b0;
      end
      begin
        for (int c = 0; c < 12; c++) begin
          @(posedge clk); #1;
          ready_out = !(c >= 1 && c <= 7);
        end
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (pstall) begin
            n_checks++;
            if (valid_out !== 1'b1 || fixed_out !== pval) begin
              n_fail++;
              $display("FAIL bp_stall_hold: got v=%b %h want v=1 %h", valid_out, fixed_out, pval);
            end
          end
          if (valid_out === 1'b1 && ready_out === 1'b1) got.push_back(fixed_out);
          pstall = (valid_out === 1'b1 && ready_out === 1'b0);
          pval   = fixed_out;
        end
      end
    join
    n_checks++;
    if (!saw_low) begin n_fail++; $display("FAIL bp_ready_in_drop: got never-low want low"); end
    n_checks++;
    if (got.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) begin
        n_checks++;
        if (got[i] !== vexp[i]) begin
          n_fail++;
          $display("FAIL bp_item%0d: got %h want %h", i, got[i], vexp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit stale;
    @(posedge clk); #1;
    ready_out = 1'b0; valid_in = 1'b1; float_in = 16'h3C00;
    @(posedge clk); #1; float_in = 16'h0400;
    @(posedge clk); #1; float_in = 16'h7C00;
    @(posedge clk); #1; valid_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b1 || ready_in !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_full: got v=%b rdy=%b want v=1 rdy=0", valid_out, ready_in);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; ready_out = 1'b1;
    @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b0 || fixed_out !== 44'd0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got v=%b %h want v=0 0", valid_out, fixed_out);
    end
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (valid_out !== 1'b0) stale = 1;
    end
    n_checks++;
    if (stale) begin n_fail++; $display("FAIL mid_no_stale: got stale output want none"); end
  endtask

  task automatic test_sweep();
    localparam int N = 5042;
    logic [15:0] q [$];
    logic [15:0] f;
    logic [43:0] want;
    logic        acc;
    int          sent, recvd;
    bit          done;
    sent = 0; recvd = 0; done = 0;
    q.delete();
    @(posedge clk); #1;
    valid_in = 1'b1; float_in = 16'h0000;
    fork
      begin
        for (int c = 0; c < 30000 && sent < N; c++) begin
          @(negedge clk);
          acc = ready_in;
          @(posedge clk); #1;
          if (acc) begin
            q.push_back(float_in);
            sent++;
            float_in = 16'(sent * 13);
          end
        end
        valid_in = 1'b0;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ready_out = ($urandom_range(0, 3) != 0);
        end
        ready_out = 1'b1;
      end
      begin
        for (int c = 0; c < 30000 && recvd < N; c++) begin
          @(negedge clk);
          if (valid_out === 1'b1 && ready_out === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL sweep_spurious: got %h want no output", fixed_out);
            end else begin
              f = q.pop_front();
              want = model(f);
              if (fixed_out !== want) begin
                n_fail++;
                $display("FAIL sweep_%h: got %h want %h", f, fixed_out, want);
              end
            end
            recvd++;
          end
        end
        done = 1;
      end
    join
    n_checks++;
    if (recvd != N) begin n_fail++; $display("FAIL sweep_count: got %0d want %0d", recvd, N); end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1; float_in = '0;
    test_reset();
    test_zero();
    test_smallest();
    test_extremes();
    test_backpressure();
    test_reset_midstream();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
